// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side consumer handshake: holding register, status flags and read acknowledge.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  logic                 rd_ack;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rd_ack
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rd_ack
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // synchronizer flop pair
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start validation, mid-bit data sampling LSB first,
// stop-bit check, and a valid/ack holding register with overrun and framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rxd,
  input  logic     sample_tick,
  uart_rx_if.master rx_if
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_ZERO  = {OS_W{1'b0}};
  localparam logic [OS_W-1:0] OS_ONE   = OS_W'(1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] BC_ZERO  = {BC_W{1'b0}};
  localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);

  uart_rx_state_e       state_r, state_nxt_s;
  logic [OS_W-1:0]      os_cnt_r, os_cnt_nxt_s;
  logic [BC_W-1:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_nxt_s;
  logic                 deliver_s;
  logic                 ferr_s;
  logic                 rxd_s;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      os_cnt_r  <= OS_ZERO;
      bit_cnt_r <= BC_ZERO;
      shreg_r   <= {DATA_BITS{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      os_cnt_r  <= os_cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shreg_r   <= shreg_nxt_s;
    end
  end

  // next-state decode, evaluated only on sample ticks
  always_comb begin
    state_nxt_s = state_r;
    if (sample_tick) begin
      case (state_r)
        ST_IDLE:  state_nxt_s = rxd_s ? ST_IDLE : ST_START;
        ST_START: begin
          if (os_cnt_r == OS_HALF) state_nxt_s = rxd_s ? ST_IDLE : ST_DATA;
          else                     state_nxt_s = ST_START;
        end
        ST_DATA: begin
          if (os_cnt_r == OS_LAST && bit_cnt_r == BC_LAST) state_nxt_s = ST_STOP;
          else                                              state_nxt_s = ST_DATA;
        end
        ST_STOP: begin
          if (os_cnt_r == OS_LAST) state_nxt_s = rxd_s ? ST_IDLE : ST_BRK;
          else                     state_nxt_s = ST_STOP;
        end
        // a held-low line must return high before a new start can arm
        ST_BRK:   state_nxt_s = rxd_s ? ST_IDLE : ST_BRK;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // counters, shifter and per-frame events
  always_comb begin
    os_cnt_nxt_s  = os_cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shreg_nxt_s   = shreg_r;
    deliver_s     = 1'b0;
    ferr_s        = 1'b0;
    if (sample_tick) begin
      case (state_r)
        ST_IDLE: begin
          os_cnt_nxt_s  = OS_ZERO;
          bit_cnt_nxt_s = BC_ZERO;
        end
        ST_START: begin
          if (os_cnt_r == OS_HALF) begin
            os_cnt_nxt_s  = OS_ZERO;
            bit_cnt_nxt_s = BC_ZERO;
          end else begin
            os_cnt_nxt_s  = os_cnt_r + OS_ONE;
          end
        end
        ST_DATA: begin
          if (os_cnt_r == OS_LAST) begin
            shreg_nxt_s   = {rxd_s, shreg_r[DATA_BITS-1:1]};
            os_cnt_nxt_s  = OS_ZERO;
            bit_cnt_nxt_s = bit_cnt_r + BC_ONE;
          end else begin
            os_cnt_nxt_s  = os_cnt_r + OS_ONE;
          end
        end
        ST_STOP: begin
          if (os_cnt_r == OS_LAST) begin
            os_cnt_nxt_s = OS_ZERO;
            if (rxd_s) deliver_s = 1'b1;
            else       ferr_s    = 1'b1;
          end else begin
            os_cnt_nxt_s = os_cnt_r + OS_ONE;
          end
        end
        ST_BRK: begin
          os_cnt_nxt_s = OS_ZERO;
        end
        default: begin
          os_cnt_nxt_s  = OS_ZERO;
          bit_cnt_nxt_s = BC_ZERO;
        end
      endcase
    end else begin
      os_cnt_nxt_s = os_cnt_r;
    end
  end

  // output holding register and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (deliver_s) begin
        rx_data_r  <= shreg_r;
        rx_valid_r <= 1'b1;
        // an ack in the same clock consumes the old byte, so no overrun
        overrun_r  <= rx_valid_r & ~rx_if.rd_ack;
      end else if (rx_if.rd_ack && rx_valid_r) begin
        rx_valid_r <= 1'b0;
        overrun_r  <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
        overrun_r  <= overrun_r;
      end
    end
  end

  assign rx_if.rx_data   = rx_data_r;
  assign rx_if.rx_valid  = rx_valid_r;
  assign rx_if.frame_err = frame_err_r;
  assign rx_if.overrun   = overrun_r;
  assign rx_if.busy      = busy_r;

endmodule
